// File: rtl/button_conditioner.sv
// Per-bit 2-flop synchroniser, counter debounce and registered rise/fall/repeat pulses.
// Optional auto-repeat for REPEAT_MASK bits is built when BTN_REPEAT_EN is defined.
module button_conditioner #(
    parameter int unsigned             N_BTN        = 7,
    parameter int unsigned             DEBOUNCE_CYC = 1024,
    parameter int unsigned             REPEAT_DELAY = 4096,
    parameter int unsigned             REPEAT_RATE  = 1024,
    parameter logic [N_BTN-1:0]        REPEAT_MASK  = 7'b0000011
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall,
    output logic [N_BTN-1:0] btn_rpt
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);

    if (DEBOUNCE_CYC < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 || $bits(REPEAT_MASK) != N_BTN) begin : g_bad_cfg
        $error("button_conditioner: invalid parameter set");
    end

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] level_nxt;
    logic [N_BTN-1:0] rise_nxt;
    logic [N_BTN-1:0] fall_nxt;
    logic [CW-1:0]    cnt     [N_BTN];
    logic [CW-1:0]    cnt_nxt [N_BTN];

    always_comb begin
        for (int unsigned i = 0; i < N_BTN; i++) begin
            level_nxt[i] = btn_level[i];
            cnt_nxt[i]   = '0;
            if (sync2[i] != btn_level[i]) begin
                if (cnt[i] == DB_LAST) begin
                    level_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    assign rise_nxt = level_nxt & ~btn_level;
    assign fall_nxt = ~level_nxt & btn_level;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1     <= '0;
            sync2     <= '0;
            btn_level <= '0;
            btn_rise  <= '0;
            btn_fall  <= '0;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1     <= btn_raw;
            sync2     <= sync1;
            btn_level <= level_nxt;
            btn_rise  <= rise_nxt;
            btn_fall  <= fall_nxt;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_e;

    rpt_state_e       state      [N_BTN];
    rpt_state_e       state_nxt  [N_BTN];
    logic [RW-1:0]    rcnt       [N_BTN];
    logic [RW-1:0]    rcnt_nxt   [N_BTN];
    logic [N_BTN-1:0] rpt_nxt;

    // Decisions use this edge's level transition so btn_rpt lines up with btn_rise.
    always_comb begin
        for (int unsigned i = 0; i < N_BTN; i++) begin
            state_nxt[i] = state[i];
            rcnt_nxt[i]  = rcnt[i];
            rpt_nxt[i]   = 1'b0;
            if (!REPEAT_MASK[i]) begin
                state_nxt[i] = RPT_IDLE;
                rcnt_nxt[i]  = '0;
                rpt_nxt[i]   = rise_nxt[i];
            end else if (fall_nxt[i]) begin
                state_nxt[i] = RPT_IDLE;
                rcnt_nxt[i]  = '0;
            end else begin
                case (state[i])
                    RPT_IDLE: begin
                        if (rise_nxt[i]) begin
                            state_nxt[i] = RPT_DELAY;
                            rcnt_nxt[i]  = '0;
                            rpt_nxt[i]   = 1'b1;
                        end
                    end
                    RPT_DELAY: begin
                        if (rcnt[i] == DELAY_LAST) begin
                            state_nxt[i] = RPT_REPEAT;
                            rcnt_nxt[i]  = '0;
                            rpt_nxt[i]   = 1'b1;
                        end else begin
                            rcnt_nxt[i] = rcnt[i] + RW'(1);
                        end
                    end
                    RPT_REPEAT: begin
                        if (rcnt[i] == RATE_LAST) begin
                            rcnt_nxt[i] = '0;
                            rpt_nxt[i]  = 1'b1;
                        end else begin
                            rcnt_nxt[i] = rcnt[i] + RW'(1);
                        end
                    end
                    default: begin
                        state_nxt[i] = RPT_IDLE;
                        rcnt_nxt[i]  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            btn_rpt <= '0;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                state[i] <= RPT_IDLE;
                rcnt[i]  <= '0;
            end
        end else begin
            btn_rpt <= rpt_nxt;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                state[i] <= state_nxt[i];
                rcnt[i]  <= rcnt_nxt[i];
            end
        end
    end
`else
    assign btn_rpt = btn_rise;
`endif

endmodule
